control_unit: RTL

Multi-cycle controller driving the accumulator datapath (13-bit PC, 16-bit AC, add/sub ALU, 4:1 PC and AC source muxes). Fetches 16-bit instructions over a ready-handshake memory port, latches them into an internal IR, decodes them, and issues the mux selects, AC load, ALU op and memory strobes the datapath consumes. It is the control-side counterpart of the datapath. It does not compute data itself.

---
 rtl/control_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: FETCH/DECODE/EXEC/HALT controller for the accumulator datapath.
// Define CTRL_TIMEOUT_EN to add the memory-wait timeout (sticky o_bus_err, forced HALT).
module control_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_mem_rdata,
   input  logic        i_mem_ready,
   input  logic        i_ac_zero,
   output logic [1:0]  o_pc_sel,
   output logic [1:0]  o_ac_sel,
   output logic        o_ac_load,
   output logic        o_alu_op,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic        o_addr_sel,
   output logic [15:0] o_ir,
   output logic        o_halted,
   output logic        o_bus_err
);
   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_STA = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;
   localparam logic [2:0] OP_JEZ = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;
   state_t r_state, w_next;
   logic [15:0] r_ir;
   logic [2:0] w_op;
   logic w_rd_op, w_mem_op, w_wait, w_done, w_timeout;
   assign w_op = r_ir[15:13];
   assign w_rd_op = w_op == OP_LDA || w_op == OP_ADD || w_op == OP_SUB;
   assign w_mem_op = w_rd_op || w_op == OP_STA;
   assign w_wait = !i_mem_ready && (r_state == S_FETCH || (r_state == S_EXEC && w_mem_op));
   assign w_done = !w_mem_op || i_mem_ready;
   assign o_ir = r_ir;
`ifdef CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] r_cnt;
   logic r_bus_err;
   // Counter only runs across consecutive wait cycles; any ready or state change clears it.
   assign w_timeout = w_wait && r_cnt == LP_LAST;
   assign o_bus_err = r_bus_err;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_cnt <= w_wait ? r_cnt + CW'(1) : '0;
         r_bus_err <= r_bus_err | w_timeout;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = TIMEOUT_CYCLES == 0;
   assign w_timeout = 1'b0;
   assign o_bus_err = 1'b0;
`endif
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_FETCH;
         r_ir <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && i_mem_ready) r_ir <= i_mem_rdata;
      end
   end
   always_comb begin
      w_next = r_state;
      o_pc_sel = 2'b10;
      o_ac_sel = 2'b00;
      o_ac_load = 1'b0;
      o_alu_op = 1'b0;
      o_mem_rd = 1'b0;
      o_mem_wr = 1'b0;
      o_addr_sel = 1'b0;
      o_halted = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_rd = 1'b1;
            w_next = i_mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: w_next = w_op == OP_HLT ? S_HALT : S_EXEC;
         S_EXEC: begin
            o_mem_rd = w_rd_op;
            o_mem_wr = w_op == OP_STA;
            o_addr_sel = w_mem_op;
            o_ac_sel = w_op == OP_LDA ? 2'b01 : 2'b00;
            o_alu_op = w_op == OP_SUB;
            o_ac_load = w_done && w_rd_op;
            o_pc_sel = !w_done ? 2'b10 :
                       (w_op == OP_JMP || (w_op == OP_JEZ && i_ac_zero)) ? 2'b01 : 2'b00;
            w_next = w_done ? S_FETCH : S_EXEC;
         end
         default: o_halted = 1'b1;
      endcase
      if (w_timeout) w_next = S_HALT;
      // PC is forced to zero for as long as reset is held.
      if (i_reset) o_pc_sel = 2'b11;
   end
endmodule
